// File: rtl/comm_pkg.sv
// Shared definitions for the matrix-converter commutation monitor:
// connection codes, phase indices, switch-bit mapping and phase FSM encoding.
package comm_pkg;

    localparam logic [1:0] CONN_NUL = 2'b00;
    localparam logic [1:0] CONN_LAA = 2'b01;
    localparam logic [1:0] CONN_LBB = 2'b10;
    localparam logic [1:0] CONN_LCC = 2'b11;

    localparam int unsigned PHASE_A = 0;
    localparam int unsigned PHASE_B = 1;
    localparam int unsigned PHASE_C = 2;
    localparam int unsigned NUM_PHASES = 3;

    typedef enum logic [1:0] {
        ST_SETTLED = 2'd0,
        ST_TRANSIT = 2'd1,
        ST_FAULT   = 2'd2
    } phase_state_t;

    // Switch s = 3p + i; its forward IGBT is bit 2s, reverse IGBT bit 2s+1.
    function automatic int unsigned fwd_bit(input int unsigned p, input int unsigned i);
        return 2 * (3 * p + i);
    endfunction

    function automatic int unsigned rev_bit(input int unsigned p, input int unsigned i);
        return 2 * (3 * p + i) + 1;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? lim : v + 8'd1;
    endfunction

endpackage

// File: rtl/comm_phase_mon.sv
// One output phase of the commutation monitor: decode, fault filters and FSM.
// Open-circuit detection is built only when COMM_MON_OPEN_DETECT_EN is defined.
module comm_phase_mon
    import comm_pkg::*;
#(
    parameter int unsigned FILT_CYCLES    = 2,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] slice,
    input  logic       current_sign,
    input  logic       cur_valid,
    input  logic       clr_faults,
    output logic       short_flag,
    output logic       open_flag,
    output logic       timeout_flag,
    output logic [1:0] load_state,
    output logic       settled
);

    localparam logic [7:0] FILT_LIM    = 8'(FILT_CYCLES);
    localparam logic [7:0] SETTLE_LIM  = 8'(SETTLE_CYCLES);
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    logic [2:0]   fwd, rev;
    logic         short_term, short_hit, short_q, short_n;
    logic [7:0]   short_cnt, short_cnt_n;
    logic         open_hit;
    logic [1:0]   conn;
    logic         conn_legal, changed, stable;
    logic [5:0]   prev_slice;
    phase_state_t state_q, state_n;
    logic [7:0]   settle_cnt, settle_n, settle_inc;
    logic [7:0]   transit_cnt, transit_n, transit_inc;
    logic         timeout_q, timeout_n, settled_q, settled_n;
    logic [1:0]   load_q, load_n;

    // Decode: a legal connection is exactly one switch fully on, or everything off.
    always_comb begin
        fwd        = '0;
        rev        = '0;
        short_term = 1'b0;
        conn       = CONN_NUL;
        conn_legal = (slice == 6'd0);
        for (int i = 0; i < 3; i++) begin
            fwd[i] = slice[fwd_bit(0, i)];
            rev[i] = slice[rev_bit(0, i)];
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (i != j) short_term |= fwd[i] & rev[j];
            end
            if (slice == (6'b000011 << (2 * i))) begin
                conn       = 2'(i + 1);
                conn_legal = 1'b1;
            end
        end
    end

    assign changed = (slice != prev_slice);
    assign stable  = !changed && conn_legal;

    always_comb begin
        short_cnt_n = short_term ? sat_inc(short_cnt, FILT_LIM) : 8'd0;
        short_hit   = short_term && (short_cnt_n == FILT_LIM) && !clr_faults;
        short_n     = clr_faults ? 1'b0 : (short_q | short_hit);
        if (clr_faults) short_cnt_n = 8'd0;
    end

`ifdef COMM_MON_OPEN_DETECT_EN
    logic       open_term, open_q, open_n;
    logic [7:0] open_cnt, open_cnt_n;

    // An open is a valid current with no device conducting in its direction.
    assign open_term = cur_valid && (current_sign ? (fwd == 3'b000) : (rev == 3'b000));

    always_comb begin
        open_cnt_n = open_term ? sat_inc(open_cnt, FILT_LIM) : 8'd0;
        open_hit   = open_term && (open_cnt_n == FILT_LIM) && !clr_faults;
        open_n     = clr_faults ? 1'b0 : (open_q | open_hit);
        if (clr_faults) open_cnt_n = 8'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            open_cnt <= 8'd0;
            open_q   <= 1'b0;
        end else begin
            open_cnt <= open_cnt_n;
            open_q   <= open_n;
        end
    end

    assign open_flag = open_q;
`else
    logic unused_open_inputs;
    assign unused_open_inputs = current_sign ^ cur_valid;
    assign open_hit  = 1'b0;
    assign open_flag = 1'b0;
`endif

    // Fault entry overrides settling; clr_faults overrides any fault entry.
    always_comb begin
        state_n     = state_q;
        settle_n    = settle_cnt;
        transit_n   = transit_cnt;
        settled_n   = settled_q;
        load_n      = load_q;
        timeout_n   = timeout_q;
        settle_inc  = stable ? sat_inc(settle_cnt, SETTLE_LIM) : 8'd0;
        transit_inc = sat_inc(transit_cnt, TIMEOUT_LIM);
        unique case (state_q)
            ST_SETTLED: begin
                settle_n = settle_inc;
                if (changed) begin
                    state_n   = ST_TRANSIT;
                    settled_n = 1'b0;
                    settle_n  = 8'd0;
                    transit_n = 8'd0;
                end
            end
            ST_TRANSIT: begin
                settle_n  = settle_inc;
                transit_n = transit_inc;
                if ((transit_inc == TIMEOUT_LIM) && !clr_faults) begin
                    state_n   = ST_FAULT;
                    timeout_n = 1'b1;
                    settled_n = 1'b0;
                    settle_n  = 8'd0;
                    transit_n = 8'd0;
                end else if (settle_inc == SETTLE_LIM) begin
                    state_n   = ST_SETTLED;
                    settled_n = 1'b1;
                    load_n    = conn;
                end
            end
            ST_FAULT: begin
                settled_n = 1'b0;
                settle_n  = 8'd0;
                transit_n = 8'd0;
                if (clr_faults) state_n = ST_TRANSIT;
            end
            default: state_n = ST_TRANSIT;
        endcase
        if (clr_faults) begin
            timeout_n = 1'b0;
        end else if (short_hit || open_hit) begin
            state_n   = ST_FAULT;
            settled_n = 1'b0;
            load_n    = load_q;
            settle_n  = 8'd0;
            transit_n = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_TRANSIT;
            prev_slice  <= 6'd0;
            settle_cnt  <= 8'd0;
            transit_cnt <= 8'd0;
            short_cnt   <= 8'd0;
            short_q     <= 1'b0;
            timeout_q   <= 1'b0;
            settled_q   <= 1'b0;
            load_q      <= CONN_NUL;
        end else begin
            state_q     <= state_n;
            prev_slice  <= slice;
            settle_cnt  <= settle_n;
            transit_cnt <= transit_n;
            short_cnt   <= short_cnt_n;
            short_q     <= short_n;
            timeout_q   <= timeout_n;
            settled_q   <= settled_n;
            load_q      <= load_n;
        end
    end

    assign short_flag   = short_q;
    assign timeout_flag = timeout_q;
    assign load_state   = load_q;
    assign settled      = settled_q;

endmodule

// File: rtl/commutation_monitor.sv
// Passive shoot-through / open / timeout checker on the 18-bit gate vector.
// Define COMM_MON_OPEN_DETECT_EN to build the open-circuit detection.
module commutation_monitor
    import comm_pkg::*;
#(
    parameter int unsigned FILT_CYCLES    = 2,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] sout,
    input  logic [2:0]  current_sign,
    input  logic [2:0]  cur_valid,
    input  logic        clr_faults,
    output logic [2:0]  shorts,
    output logic [2:0]  opens,
    output logic [2:0]  timeout,
    output logic [5:0]  load_state,
    output logic [2:0]  settled,
    output logic        fault
);

    for (genvar p = 0; p < NUM_PHASES; p++) begin : g_phase
        comm_phase_mon #(
            .FILT_CYCLES   (FILT_CYCLES),
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_mon (
            .clk         (clk),
            .rst         (rst),
            .slice       (sout[fwd_bit(p, 0) +: 6]),
            .current_sign(current_sign[p]),
            .cur_valid   (cur_valid[p]),
            .clr_faults  (clr_faults),
            .short_flag  (shorts[p]),
            .open_flag   (opens[p]),
            .timeout_flag(timeout[p]),
            .load_state  (load_state[2*p +: 2]),
            .settled     (settled[p])
        );
    end

`ifdef COMM_MON_OPEN_DETECT_EN
    assign fault = |{shorts, opens, timeout};
`else
    assign fault = |{shorts, timeout};
`endif

endmodule

// File: tb/tb_commutation_monitor.sv
// Scoreboard bench for commutation_monitor: directed gate vectors, queued expectations.
module tb_commutation_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] sout;
    logic [2:0]  current_sign, cur_valid;
    logic        clr_faults;
    logic [2:0]  shorts, opens, timeout, settled;
    logic [5:0]  load_state;
    logic        fault;

`ifdef COMM_MON_OPEN_DETECT_EN
    localparam bit OPEN_EN = 1'b1;
`else
    localparam bit OPEN_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [18:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [18:0] act;
    event        sample_ev;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    commutation_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .sout        (sout),
        .current_sign(current_sign),
        .cur_valid   (cur_valid),
        .clr_faults  (clr_faults),
        .shorts      (shorts),
        .opens       (opens),
        .timeout     (timeout),
        .load_state  (load_state),
        .settled     (settled),
        .fault       (fault)
    );

    // Monitor: drains every queued expectation against the outputs at sample time.
    initial begin
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                act   = {fault, shorts, opens, timeout, load_state, settled};
                vectors++;
                if (act !== mon_e.exp) begin
                    miscompares++;
                    $display("[TB] FAIL %s: got {fault,shorts,opens,timeout,load,settled}=%b_%b_%b_%b_%b_%b required %b_%b_%b_%b_%b_%b",
                             mon_e.name, act[18], act[17:15], act[14:12], act[11:9], act[8:3], act[2:0],
                             mon_e.exp[18], mon_e.exp[17:15], mon_e.exp[14:12], mon_e.exp[11:9],
                             mon_e.exp[8:3], mon_e.exp[2:0]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic f, input logic [2:0] sh,
                               input logic [2:0] op, input logic [2:0] to,
                               input logic [5:0] ls, input logic [2:0] st);
        exp_t e;
        e.name = name;
        e.exp  = {f, sh, op, to, ls, st};
        exp_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic applyStimulus(input logic [17:0] s, input int n);
        sout = s;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired before completion");
        $fatal(1);
    end

    initial begin
        rst          = 1'b0;
        sout         = 18'h00000;
        current_sign = 3'b001;
        cur_valid    = 3'b000;
        clr_faults   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_state", 1'b0, 3'b000, 3'b000, 3'b000, 6'b000000, 3'b000);

        // Decode of one LAA/LBB/LCC connection per phase
        sout = 18'h30303;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(18'h30303, 4);
        checkOutput("decode_not_yet", 1'b0, 3'b000, 3'b000, 3'b000, 6'b000000, 3'b000);
        applyStimulus(18'h30303, 1);
        checkOutput("decode_settled", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b111);

        // Legal four-step commutation A -> B on phase a
        cur_valid = 3'b111;
        applyStimulus(18'h30301, 1);
        checkOutput("step_first_change", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b110);
        applyStimulus(18'h30301, 2);
        checkOutput("step_01", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b110);
        applyStimulus(18'h30305, 3);
        checkOutput("step_05", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b110);
        applyStimulus(18'h30304, 3);
        checkOutput("step_04", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b110);
        applyStimulus(18'h3030C, 4);
        checkOutput("step_0C_not_yet", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b110);
        applyStimulus(18'h3030C, 1);
        checkOutput("step_0C_settled", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111010, 3'b111);

        // Short filter
        cur_valid = 3'b000;
        applyStimulus(18'h30309, 1);
        checkOutput("short_one_cycle", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111010, 3'b110);
        applyStimulus(18'h30303, 5);
        checkOutput("short_resettle", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b111);
        applyStimulus(18'h30309, 2);
        checkOutput("short_two_cycles", 1'b1, 3'b001, 3'b000, 3'b000, 6'b111001, 3'b110);
        applyStimulus(18'h30303, 3);
        checkOutput("short_latched", 1'b1, 3'b001, 3'b000, 3'b000, 6'b111001, 3'b110);
        clr_faults = 1'b1;
        applyStimulus(18'h30303, 1);
        clr_faults = 1'b0;
        checkOutput("short_cleared", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b110);
        applyStimulus(18'h30303, 3);
        checkOutput("short_clr_not_yet", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b110);
        applyStimulus(18'h30303, 1);
        checkOutput("short_clr_settled", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b111);

        // Open circuit: A reverse only with forward current on phase a
        current_sign = 3'b001;
        cur_valid    = 3'b001;
        applyStimulus(18'h30302, 1);
        checkOutput("open_one_cycle", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b110);
        applyStimulus(18'h30302, 1);
        checkOutput("open_two_cycles", OPEN_EN, 3'b000, {2'b00, OPEN_EN}, 3'b000, 6'b111001, 3'b110);
        clr_faults = 1'b1;
        applyStimulus(18'h30303, 1);
        clr_faults = 1'b0;
        checkOutput("open_cleared", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b110);
        applyStimulus(18'h30303, 3);
        checkOutput("open_clr_not_yet", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b110);
        applyStimulus(18'h30303, 1);
        checkOutput("open_clr_settled", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b111);
        cur_valid = 3'b000;
        applyStimulus(18'h30302, 3);
        checkOutput("open_no_valid", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b110);
        applyStimulus(18'h30303, 5);
        checkOutput("open_no_valid_resettle", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b111);

        // Timeout on phase b: slice toggles 0x01 / 0x03 every two cycles
        for (int j = 0; j < 64; j++) begin
            applyStimulus((((j / 2) % 2) == 0) ? 18'h30043 : 18'h300C3, 1);
        end
        checkOutput("timeout_edge63", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b101);
        applyStimulus(18'h30043, 1);
        checkOutput("timeout_edge64", 1'b1, 3'b000, 3'b000, 3'b010, 6'b111001, 3'b101);

        // Asynchronous reset while a fault is latched
        rst = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 3'b000, 3'b000, 3'b000, 6'b000000, 3'b000);
        sout = 18'h30303;
        @(negedge clk);
        checkOutput("reset_held", 1'b0, 3'b000, 3'b000, 3'b000, 6'b000000, 3'b000);
        rst = 1'b1;
        applyStimulus(18'h30303, 5);
        checkOutput("post_reset_settled", 1'b0, 3'b000, 3'b000, 3'b000, 6'b111001, 3'b111);

        #2;
        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (vectors < 12) begin
            $display("[TB] FAIL only %0d vectors were compared", vectors);
        end
        if (miscompares != 0) begin
            $display("[TB] FAIL %0d miscompares", miscompares);
        end else begin
            $display("[TB] PASS");
        end
        $finish;
    end

endmodule

// File: doc/commutation_monitor.md
Name: commutation_monitor

Overview:
- Passive checker at the switch-drive side of the matrix-converter commutation FSM. It reads the 18-bit gate vector that the FSM drives and feeds back per-output-phase shorts.
- Decodes the live switch pattern into per-phase load connections using the NUL/LAA/LBB/LCC codes.
- Filters and latches shoot-through (short), open-circuit and commutation-timeout faults.
- The sequencer consumes the outputs, and the sout/shorts loop closes through the FSM.

Parameters:
- FILT_CYCLES, 2, consecutive cycles a fault condition must persist before it is flagged (range 1..255).
- SETTLE_CYCLES, 4, cycles a phase's 6-bit slice must stay unchanged and legal before it is reported settled (range 1..255).
- TIMEOUT_CYCLES, 64, maximum cycles a phase may remain in transit before a timeout fault (range 1..255; must exceed SETTLE_CYCLES).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sout  in  18  gate vector. Switch s = 3*p + i, where p = output phase a/b/c (0..2) and i = input phase A/B/C (0..2). sout[2s] = forward IGBT (input->load); sout[2s+1] = reverse IGBT (load->input).
- current_sign  in  3  per output phase: 1 = current flows input->load
- cur_valid  in  3  per output phase: current magnitude above the sensor threshold
- clr_faults  in  1  single-cycle pulse; clears latched faults
- shorts  out  3  latched filtered short per output phase
- opens  out  3  latched filtered open-circuit per output phase
- timeout  out  3  latched commutation timeout per output phase
- load_state  out  6  {c,b,a} connection codes, 2 bits per phase: 00 NUL, 01 LAA, 10 LBB, 11 LCC
- settled  out  3  per-phase settled flag
- fault  out  1  OR of shorts, opens and timeout

Behaviour:
- Reset (rst = 0, asynchronous): all outputs 0; load_state = 6'b000000; all counters 0; every phase FSM in TRANSIT.
- All outputs are registered.
- Instantaneous per-phase terms, combinational from the current sout slice:
  - short_i: fwd(i) & rev(j) for some i != j.
  - open_i: cur_valid[p], and no device conducting in the current_sign[p] direction is on.
  - conn: code i+1 if exactly one switch has both IGBTs on and no other IGBT is on; NUL if all six IGBTs are off; otherwise illegal.
- Filters:
  - Each phase has a saturating counter per fault term. It increments on every edge where the term is true and clears to 0 on any edge where it is false.
  - The flag sets on the edge at which the count reaches FILT_CYCLES. With FILT = 2, a term true at edges k and k+1 raises the flag after edge k+1.
  - Flags stay latched until a clr_faults edge. A clr_faults edge also clears the counters.
  - If the term is still true on the clr_faults edge, filtering restarts from 0.
- Per-phase FSM states: SETTLED, TRANSIT, FAULT.
  - SETTLED -> TRANSIT: the slice differs from the previous cycle's slice. The same edge sets settled[p] = 0. load_state holds its last value.
  - TRANSIT -> SETTLED: the slice is unchanged and conn is legal for SETTLE_CYCLES consecutive edges. The same edge sets settled[p] = 1 and load_state[2p+1:2p] = conn.
  - TRANSIT -> FAULT: the transit counter (cycles since entering TRANSIT) reaches TIMEOUT_CYCLES. The same edge sets timeout[p].
  - any state -> FAULT: shorts[p] or opens[p] sets.
  - FAULT -> TRANSIT: on a clr_faults edge; the transit and settle counters reset.
- Any slice change restarts the settle count.
- In FAULT, settled[p] = 0 and load_state is frozen.
- Simultaneous events: fault entry takes priority over settling on the same edge. clr_faults takes priority over a fault that would set on the same edge.
- Phases are fully independent.

Optional Feature:
- Macro: COMM_MON_OPEN_DETECT_EN.
- Defined: open_i logic, the open filters and opens[2:0] are built as above.
- Undefined: opens is tied to 3'b000, the open filter hardware is removed, and fault excludes opens.

Decomposition:
- Shared package comm_pkg holds:
  - the 2-bit NUL/LAA/LBB/LCC localparams;
  - phase index constants;
  - the switch-bit index function (s = 3p+i; fwd bit 2s, rev bit 2s+1);
  - the FSM state encoding.
- Sub-module comm_phase_mon: one output phase (6-bit slice, filters, FSM). Instantiated 3 times; the top level does only the fault OR and output concatenation.

Test Plan:
- Decode: reset, then sout = 18'h30303 held for 4 cycles -> settled = 3'b111, load_state = 6'b111001, fault = 0.
- Legal 4-step on phase a, current_sign = 3'b001, cur_valid = 3'b111. Slice a steps 0x3 -> 0x1 -> 0x5 -> 0x4 -> 0xC, each held 3 cycles:
  - shorts = 0 and opens = 0 throughout;
  - settled[0] drops on the first change;
  - 4 cycles after 0xC, settled[0] = 1 and load_state[1:0] = 2'b10.
- Short filter, slice a = 0x9 (A fwd + B rev), FILT = 2:
  - held 1 cycle -> no flag;
  - held 2 cycles -> shorts[0] = 1 and fault = 1, latched after the slice returns to 0x3;
  - clr_faults pulse -> shorts[0] = 0, then re-settles after 4 cycles.
- Open (macro defined), slice a = 0x2 (A rev only), current_sign[0] = 1, cur_valid[0] = 1:
  - held 2 cycles -> opens[0] = 1;
  - with cur_valid[0] = 0 -> no flag.
- Timeout: slice b toggles between 0x040 and 0x0C0 every 2 cycles -> timeout[1] = 1 at edge 64 after leaving SETTLED; phases a and c unaffected.
- Async reset: assert rst low while faults are latched -> all outputs 0 immediately without a clock edge; after release, settles normally.
